pipe_reg_chain: RTL and testbench
=================================

PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

Interface
REQ-001 Parameter WIDTH, default 8: payload width in bits; legal range 1..1024.
REQ-002 Parameter STAGES, default 2: number of cascaded register slices; legal range 1..16.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 flush  input  1  synchronous discard of all held entries.
REQ-006 in_valid  input  1  upstream offers in_data.
REQ-007 in_ready  output  1  chain accepts in_data this cycle; registered output.
REQ-008 in_data  input  WIDTH  upstream payload.
REQ-009 out_valid  output  1  out_data holds a valid entry.
REQ-010 out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 out_data  output  WIDTH  head-of-chain payload; registered output.
REQ-012 occupancy  output  $clog2(2*STAGES+1)  count of valid entries held across all slices.

Function
REQ-013 Transfers SHALL occur only on a cycle with valid and ready both high on a port (fire); a payload SHALL be delivered exactly once, in order, unmodified.
REQ-014 Each slice SHALL be a 2-entry skid buffer (main + skid register) with state EMPTY, BUSY (main valid) or FULL (main and skid valid).
REQ-015 Slice transitions: EMPTY + in fire -> BUSY; BUSY + in fire only -> FULL (skid <= in); BUSY + out fire only -> EMPTY; BUSY + in fire and out fire -> BUSY (main <= in); FULL + out fire -> BUSY (main <= skid); all other cases hold.
REQ-016 Slice in_ready SHALL be high exactly when state != FULL; slice out_valid SHALL be high exactly when state != EMPTY; neither SHALL depend combinationally on the other port.
REQ-017 Slice k out_valid/out_data/in_ready SHALL connect to slice k+1 in_valid/in_data/out_ready; slice 0 faces the input port, slice STAGES-1 faces the output port.
REQ-018 Latency from input fire into an empty chain to out_valid high SHALL be STAGES cycles.
REQ-019 With out_ready held high, the chain SHALL sustain one fire per cycle on both ports with no bubbles.
REQ-020 With out_ready held low, the chain SHALL accept exactly 2*STAGES entries, then drop in_ready.
REQ-021 occupancy SHALL increment on input fire, decrement on output fire, hold when both or neither occur, and never exceed 2*STAGES.
REQ-022 flush high SHALL force every slice to EMPTY and occupancy to 0 on the next edge; any fire in the flush cycle SHALL be discarded; flush SHALL take priority over all transitions.
REQ-023 in_data while in_valid is low SHALL have no effect; out_data while out_valid is low is don't-care.

Reset
REQ-024 rst high SHALL set every slice to EMPTY, out_valid 0, in_ready 1, occupancy 0 on the next edge; out_data SHALL reset to 0.
REQ-025 rst SHALL take priority over flush and all fires; entries in flight at reset SHALL be lost without being delivered.
REQ-026 Payload registers other than the output-facing main register need no reset.

Structure
REQ-027 A shared package pipe_pkg SHALL hold the slice state enum (EMPTY, BUSY, FULL) and the occupancy-width helper function.
REQ-028 Sub-module reg_slice (parameter WIDTH) SHALL implement one skid slice; pipe_reg_chain SHALL instantiate STAGES copies in a generate loop and own the occupancy counter.

Verification (WIDTH=8, STAGES=3)
REQ-029 After rst, present 0x11 with out_ready=1 -> out_valid high with out_data 0x11 exactly 3 cycles after the fire; occupancy 1 -> 0.
REQ-030 Stream 0x00..0x3F with out_ready=1 -> 64 consecutive output fires, in order, no gap after the first; occupancy constant 3 in steady state.
REQ-031 out_ready=0, in_valid=1 continuously with 0xA0.. -> 6 entries accepted, in_ready low from then on, occupancy 6; release out_ready -> 0xA0..0xA5 in order.
REQ-032 Random out_ready (50%) and in_valid (50%), 1000 payloads -> scoreboard match, no loss or duplication, occupancy equal to model every cycle.
REQ-033 Chain holding 4 entries, flush asserted with concurrent in fire 0x77 -> next cycle out_valid 0, occupancy 0, 0x77 never appears at output.
REQ-034 rst asserted mid-stream with flush also high -> next cycle out_valid 0, in_ready 1, out_data 0x00, occupancy 0; subsequent traffic correct.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and helpers for the register-slice pipeline chain.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } slice_state_t;

    // Counter width able to hold 0..2*stages.
    function automatic int occ_width(input int stages);
        return $clog2(2 * stages + 1);
    endfunction

endpackage

// File: rtl/reg_slice.sv
// One two-entry skid-buffer slice: main register faces downstream, skid
// register absorbs the one extra beat so in_ready can be a pure state decode.
module reg_slice
    import pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output slice_state_t     state
);

    // Handshake: a beat moves on a port only at a rising edge where valid and
    // ready are both high; valid never waits on ready and ready never looks at
    // valid, so both sides are plain decodes of the registered state.
    slice_state_t     state_q, state_d;
    logic [WIDTH-1:0] main_q, skid_q;
    logic             in_fire, out_fire;
    logic             load_main, load_main_from_skid, load_skid;

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign state     = state_q;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        state_d             = state_q;
        load_main           = 1'b0;
        load_main_from_skid = 1'b0;
        load_skid           = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d   = BUSY;
                    load_main = 1'b1;
                end
            end
            BUSY: begin
                case ({in_fire, out_fire})
                    2'b10: begin
                        state_d   = FULL;
                        load_skid = 1'b1;
                    end
                    2'b01: state_d = EMPTY;
                    2'b11: load_main = 1'b1;
                    default: state_d = BUSY;
                endcase
            end
            FULL: begin
                if (out_fire) begin
                    state_d             = BUSY;
                    load_main_from_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush wins over every transition; payload loads are harmless then.
        if (flush) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_main) begin
                main_q <= in_data;
            end else if (load_main_from_skid) begin
                main_q <= skid_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_q <= in_data;
        end
    end

endmodule

// File: rtl/pipe_reg_chain.sv
// Cascade of STAGES skid slices with a chain-wide occupancy counter.
module pipe_reg_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WIDTH-1:0]                in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIDTH-1:0]                out_data,
    output logic [occ_width(STAGES)-1:0]    occupancy,
    output slice_state_t [STAGES-1:0]       dbg_state
);

    localparam int OCC_W = occ_width(STAGES);

    // Link k sits between slice k-1 and slice k; link 0 is the input port.
    logic [STAGES:0]  link_valid;
    logic [STAGES:0]  link_ready;
    logic [WIDTH-1:0] link_data [STAGES+1];
    logic [OCC_W-1:0] occ_q;
    logic             chain_in_fire, chain_out_fire;

    assign link_valid[0]      = in_valid;
    assign link_data[0]       = in_data;
    assign in_ready           = link_ready[0];
    assign out_valid          = link_valid[STAGES];
    assign out_data           = link_data[STAGES];
    assign link_ready[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        reg_slice #(.WIDTH(WIDTH)) u_slice (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .in_valid  (link_valid[k]),
            .in_ready  (link_ready[k]),
            .in_data   (link_data[k]),
            .out_valid (link_valid[k+1]),
            .out_ready (link_ready[k+1]),
            .out_data  (link_data[k+1]),
            .state     (dbg_state[k])
        );
    end

    assign chain_in_fire  = in_valid && link_ready[0];
    assign chain_out_fire = link_valid[STAGES] && out_ready;
    assign occupancy      = occ_q;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            occ_q <= '0;
        end else begin
            case ({chain_in_fire, chain_out_fire})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Self-checking bench for pipe_reg_chain (WIDTH=8, STAGES=3) with a queue scoreboard.
module tb_pipe_reg_chain;
    import pipe_pkg::*;

    localparam int W = 8;
    localparam int S = 3;

    logic                  clk = 1'b0;
    logic                  rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]          in_data, out_data;
    logic [2:0]            occupancy;
    slice_state_t [S-1:0]  dbg_state;

    int           checks = 0;
    int           failures = 0;
    logic [W-1:0] exp_q[$];
    int           occ_m = 0;
    logic         ifire, ofire;
    logic [W-1:0] got, exp_v;

    pipe_reg_chain #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Drives one cycle at the falling edge, observes fires, updates the model.
    task automatic drive_cycle(input logic rs, input logic fl, input logic iv,
                               input logic [W-1:0] id, input logic ordy);
        @(negedge clk);
        rst = rs; flush = fl; in_valid = iv; in_data = id; out_ready = ordy;
        ifire = iv && in_ready && !rs && !fl;
        ofire = out_valid && ordy && !rs && !fl;
        got   = out_data;
        exp_v = 'x;
        @(posedge clk);
        #1;
        if (rs || fl) begin
            exp_q.delete();
            occ_m = 0;
        end else begin
            if (ofire) begin
                if (exp_q.size() > 0) exp_v = exp_q.pop_front();
                occ_m--;
            end
            if (ifire) begin
                exp_q.push_back(id);
                occ_m++;
            end
        end
    endtask

    task automatic test_reset();
        drive_cycle(1, 0, 0, '0, 0);
        drive_cycle(1, 0, 0, '0, 0);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
        checks++; if (dbg_state !== '0) begin failures++; $display("FAIL reset_states got=%h exp=0", dbg_state); end
        drive_cycle(0, 0, 0, '0, 0);
    endtask

    task automatic test_latency();
        int n;
        drive_cycle(0, 0, 1, 8'h11, 1);
        checks++; if (ifire !== 1'b1) begin failures++; $display("FAIL lat_accept got=%b exp=1", ifire); end
        checks++; if (occupancy !== 3'd1) begin failures++; $display("FAIL lat_occ_one got=%0d exp=1", occupancy); end
        n = 1;
        while (!out_valid && n < 10) begin
            drive_cycle(0, 0, 0, '0, 1);
            n++;
        end
        checks++; if (n != 3) begin failures++; $display("FAIL lat_cycles got=%0d exp=3", n); end
        drive_cycle(0, 0, 0, '0, 1);
        checks++; if (ofire !== 1'b1 || got !== 8'h11) begin failures++; $display("FAIL lat_data got=%h exp=11", got); end
        checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL lat_occ_zero got=%0d exp=0", occupancy); end
    endtask

    task automatic test_stream();
        int sent = 0, rcvd = 0, first = -1, last = 0, cyc = 0;
        while (rcvd < 64 && cyc < 300) begin
            drive_cycle(0, 0, sent < 64, W'(sent), 1);
            if (ifire) sent++;
            if (ofire) begin
                checks++; if (got !== exp_v) begin failures++; $display("FAIL stream_data got=%h exp=%h", got, exp_v); end
                if (first < 0) first = cyc;
                last = cyc;
                rcvd++;
                if (rcvd == 32) begin
                    checks++; if (occupancy !== 3'd3) begin failures++; $display("FAIL stream_steady_occ got=%0d exp=3", occupancy); end
                end
            end
            checks++; if (occupancy !== 3'(occ_m)) begin failures++; $display("FAIL stream_occ got=%0d exp=%0d", occupancy, occ_m); end
            cyc++;
        end
        checks++; if (rcvd != 64) begin failures++; $display("FAIL stream_count got=%0d exp=64", rcvd); end
        checks++; if (last - first != 63) begin failures++; $display("FAIL stream_gapless got=%0d exp=63", last - first); end
    endtask

    task automatic test_fill();
        int acc = 0, rcvd = 0, cyc = 0;
        for (int i = 0; i < 16; i++) begin
            drive_cycle(0, 0, 1, W'(8'hA0 + acc), 0);
            if (ifire) acc++;
        end
        checks++; if (acc != 6) begin failures++; $display("FAIL fill_accepted got=%0d exp=6", acc); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
        checks++; if (occupancy !== 3'd6) begin failures++; $display("FAIL fill_occ got=%0d exp=6", occupancy); end
        while (rcvd < 6 && cyc < 40) begin
            drive_cycle(0, 0, 0, '0, 1);
            if (ofire) begin
                checks++; if (got !== W'(8'hA0 + rcvd)) begin failures++; $display("FAIL fill_drain got=%h exp=%h", got, W'(8'hA0 + rcvd)); end
                rcvd++;
            end
            cyc++;
        end
        checks++; if (rcvd != 6) begin failures++; $display("FAIL fill_drain_count got=%0d exp=6", rcvd); end
    endtask

    task automatic test_random();
        int sent = 0, rcvd = 0, cyc = 0;
        logic iv;
        while ((sent < 1000 || exp_q.size() > 0) && cyc < 20000) begin
            iv = (sent < 1000) && 1'($urandom_range(0, 1));
            drive_cycle(0, 0, iv, W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            if (ifire) sent++;
            if (ofire) begin
                checks++; if (got !== exp_v) begin failures++; $display("FAIL random_data got=%h exp=%h", got, exp_v); end
                rcvd++;
            end
            checks++; if (occupancy !== 3'(occ_m)) begin failures++; $display("FAIL random_occ got=%0d exp=%0d", occupancy, occ_m); end
            cyc++;
        end
        checks++; if (rcvd != 1000) begin failures++; $display("FAIL random_count got=%0d exp=1000", rcvd); end
    endtask

    task automatic test_flush();
        int rcvd = 0, cyc = 0;
        for (int k = 0; k < 4; k++) drive_cycle(0, 0, 1, W'(8'h30 + k), 0);
        checks++; if (occupancy !== 3'd4) begin failures++; $display("FAIL flush_pre_occ got=%0d exp=4", occupancy); end
        drive_cycle(0, 1, 1, 8'h77, 0);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
        checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL flush_occ got=%0d exp=0", occupancy); end
        while (rcvd < 8 && cyc < 60) begin
            drive_cycle(0, 0, cyc < 8, W'(8'h40 + cyc), 1);
            if (ofire) begin
                checks++; if (got !== exp_v || got === 8'h77) begin failures++; $display("FAIL flush_after got=%h exp=%h", got, exp_v); end
                rcvd++;
            end
            cyc++;
        end
        checks++; if (rcvd != 8) begin failures++; $display("FAIL flush_after_count got=%0d exp=8", rcvd); end
    endtask

    task automatic test_reset_mid();
        int rcvd = 0, cyc = 0;
        for (int k = 0; k < 10; k++) drive_cycle(0, 0, 1, W'(8'h50 + k), 1'($urandom_range(0, 1)));
        drive_cycle(1, 1, 1, 8'hEE, 1);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL rstmid_out_data got=%h exp=00", out_data); end
        checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL rstmid_occ got=%0d exp=0", occupancy); end
        while (rcvd < 10 && cyc < 80) begin
            drive_cycle(0, 0, cyc < 10, W'(8'h60 + cyc), 1);
            if (ofire) begin
                checks++; if (got !== exp_v) begin failures++; $display("FAIL rstmid_after got=%h exp=%h", got, exp_v); end
                rcvd++;
            end
            cyc++;
        end
        checks++; if (rcvd != 10) begin failures++; $display("FAIL rstmid_after_count got=%0d exp=10", rcvd); end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        test_reset();
        test_latency();
        test_stream();
        test_fill();
        test_random();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
